// File: rtl/ofifo_drain_ctrl_if.sv
// ---------------------------------------------------------------------------
// ofifo_drain_ctrl_if
//   Bundles the job-control, output-FIFO and psum-SRAM signals of the
//   output-FIFO drain controller.
//
//   master : the drain controller (drives ofifo_rd, sram_*, busy, done)
//   slave  : the surroundings (core controller, output FIFO, psum SRAM)
//
//   Optional macro OFIFO_DRAIN_ACC_EN adds acc (latched on start) and
//   sram_q (SRAM read data) for read-modify-write accumulation.
// ---------------------------------------------------------------------------
interface ofifo_drain_ctrl_if #(
  parameter int col     = 8,
  parameter int psum_bw = 4,
  parameter int addr_bw = 11
);
  logic                       start;
  logic [addr_bw-1:0]         num_vec;
  logic [addr_bw-1:0]         base_addr;
  logic                       ofifo_valid;
  logic                       ofifo_rd;
  logic [psum_bw*col-1:0]     ofifo_data;
  logic                       sram_cen;
  logic                       sram_wen;
  logic [addr_bw-1:0]         sram_addr;
  logic [psum_bw*col-1:0]     sram_d;
  logic                       busy;
  logic                       done;
`ifdef OFIFO_DRAIN_ACC_EN
  logic                       acc;
  logic [psum_bw*col-1:0]     sram_q;
`endif

  modport master (
    input  start, num_vec, base_addr, ofifo_valid, ofifo_data,
    output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
`ifdef OFIFO_DRAIN_ACC_EN
    , input acc, sram_q
`endif
  );

  modport slave (
    output start, num_vec, base_addr, ofifo_valid, ofifo_data,
    input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d, busy, done
`ifdef OFIFO_DRAIN_ACC_EN
    , output acc, sram_q
`endif
  );
endinterface

// File: rtl/ofifo_drain_ctrl.sv
// ---------------------------------------------------------------------------
// ofifo_drain_ctrl
//   Drains psum vectors (col x psum_bw bits each) from the output FIFO into
//   consecutive psum-SRAM addresses starting at a latched base address.
//   Per vector: one FIFO read, wait RD_LAT edges, capture, one SRAM write.
//   Only one FIFO read is ever outstanding.
//
// Ports
//   clk    : clock, rising edge
//   reset  : synchronous, active-high
//   bus    : ofifo_drain_ctrl_if.master
//              start/num_vec/base_addr  job request (latched on start)
//              ofifo_valid/ofifo_rd/ofifo_data  output-FIFO read side
//              sram_cen/sram_wen/sram_addr/sram_d  psum-SRAM port (active-low)
//              busy/done  job status
//
// Optional macro OFIFO_DRAIN_ACC_EN: when defined and acc was latched high,
//   each vector is added column-wise (mod 2^psum_bw) to the old SRAM word
//   via an extra read (RDOLD) and capture (ADD) step before the write.
// ---------------------------------------------------------------------------
module ofifo_drain_ctrl #(
  parameter int col     = 8,
  parameter int psum_bw = 4,
  parameter int addr_bw = 11,
  parameter int RD_LAT  = 2
) (
  input  logic                clk,
  input  logic                reset,
  ofifo_drain_ctrl_if.master  bus
);

  localparam int DW    = psum_bw * col;
  localparam int LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_LAT,
    S_WRITE,
    S_DONE,
    S_RDOLD,
    S_ADD
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [addr_bw-1:0] r_num;
  logic [addr_bw-1:0] r_base;
  logic [addr_bw-1:0] r_idx;
  logic [addr_bw-1:0] w_idx_inc;
  logic [LAT_W-1:0]   r_lat;
  logic [DW-1:0]      r_data;
  logic               w_last;
`ifdef OFIFO_DRAIN_ACC_EN
  logic               r_acc;

  // Per-column wrap-around add; carries never cross column boundaries.
  function automatic logic [DW-1:0] col_add(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [DW-1:0] s;
    s = '0;
    for (int c = 0; c < col; c++) begin
      s[c*psum_bw +: psum_bw] = a[c*psum_bw +: psum_bw] + b[c*psum_bw +: psum_bw];
    end
    return s;
  endfunction
`endif

  assign w_idx_inc     = r_idx + 1'b1;
  assign w_last        = (w_idx_inc == r_num);
  // Address arithmetic wraps mod 2^addr_bw by construction.
  assign bus.sram_addr = r_base + r_idx;
  assign bus.sram_d    = r_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_next       = r_state;
    bus.ofifo_rd = 1'b0;
    bus.sram_cen = 1'b1;
    bus.sram_wen = 1'b1;
    bus.busy     = (r_state != S_IDLE);
    bus.done     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = (bus.num_vec == '0) ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        if (bus.ofifo_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        bus.ofifo_rd = 1'b1;
        w_next       = S_LAT;
      end
      S_LAT: begin
        if (r_lat == '0) begin
`ifdef OFIFO_DRAIN_ACC_EN
          w_next = r_acc ? S_RDOLD : S_WRITE;
`else
          w_next = S_WRITE;
`endif
        end
      end
`ifdef OFIFO_DRAIN_ACC_EN
      S_RDOLD: begin
        bus.sram_cen = 1'b0;
        w_next       = S_ADD;
      end
      S_ADD: begin
        w_next = S_WRITE;
      end
`endif
      S_WRITE: begin
        bus.sram_cen = 1'b0;
        bus.sram_wen = 1'b0;
        // Skipping WAIT when the FIFO is still valid keeps one vector per
        // RD_LAT+2 cycles on a continuously valid FIFO.
        if (w_last)               w_next = S_DONE;
        else if (bus.ofifo_valid) w_next = S_ISSUE;
        else                      w_next = S_WAIT;
      end
      S_DONE: begin
        bus.done = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // Reset abandons the job at once: no read or SRAM access in the reset
    // cycle even though the state register has not yet cleared.
    if (reset) begin
      bus.ofifo_rd = 1'b0;
      bus.sram_cen = 1'b1;
      bus.sram_wen = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_num  <= '0;
      r_base <= '0;
      r_idx  <= '0;
      r_lat  <= '0;
      r_data <= '0;
`ifdef OFIFO_DRAIN_ACC_EN
      r_acc  <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start && (bus.num_vec != '0)) begin
            r_num  <= bus.num_vec;
            r_base <= bus.base_addr;
            r_idx  <= '0;
`ifdef OFIFO_DRAIN_ACC_EN
            r_acc  <= bus.acc;
`endif
          end
        end
        S_ISSUE: r_lat <= LAT_W'(RD_LAT - 1);
        S_LAT: begin
          // Counter reaching zero marks the edge where FIFO data is valid.
          if (r_lat == '0) r_data <= bus.ofifo_data;
          else             r_lat  <= r_lat - 1'b1;
        end
`ifdef OFIFO_DRAIN_ACC_EN
        S_ADD:   r_data <= col_add(r_data, bus.sram_q);
`endif
        S_WRITE: r_idx <= w_idx_inc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ofifo_drain_ctrl.sv
`timescale 1ns/1ps
module tb_ofifo_drain_ctrl;

  localparam int COL    = 8;
  localparam int PBW    = 4;
  localparam int ABW    = 11;
  localparam int RD_LAT = 2;
  localparam int DW     = COL * PBW;
  localparam int AMASK  = (1 << ABW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ofifo_drain_ctrl_if #(.col(COL), .psum_bw(PBW), .addr_bw(ABW)) bus ();

  ofifo_drain_ctrl #(.col(COL), .psum_bw(PBW), .addr_bw(ABW), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp;
  int n_bad;
  int cyc;

  // Environment models: FIFO contents, read-latency pipe, SRAM array.
  logic [DW-1:0]  fifo_q[$];
  logic [DW-1:0]  to_produce[$];
  int             produce_from;
  bit             gappy;
  logic [DW-1:0]  pipe [RD_LAT+1];
  logic [DW-1:0]  mem  [1 << ABW];
  logic [DW-1:0]  q_pend;
  bit             q_pend_v;

  // Observation logs.
  bit             busy_at[$];
  int             rd_cyc[$];
  int             wr_cyc[$];
  logic [ABW-1:0] wr_addr[$];
  logic [DW-1:0]  wr_data[$];
  int             done_cyc[$];
  int             rd_viol;
  int             sram_acc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Column-wise add modulo 2^PBW, written with plain integer arithmetic.
  function automatic logic [DW-1:0] col_sum(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    int unsigned   x, y, m;
    r = '0;
    m = 1 << PBW;
    for (int c = 0; c < COL; c++) begin
      x = (int'(a) >> (c * PBW)) % m;
      y = (int'(b) >> (c * PBW)) % m;
      r = r | (DW'((x + y) % m) << (c * PBW));
    end
    return r;
  endfunction

  // One clock cycle: observe outputs at the negedge, update models, drive
  // the inputs sampled at the coming posedge, advance to the next negedge.
  task automatic cycle();
    busy_at.push_back(bus.busy === 1'b1);
    if (bus.done === 1'b1) done_cyc.push_back(cyc);
    if (bus.ofifo_rd === 1'b1) begin
      rd_cyc.push_back(cyc);
      if (fifo_q.size() == 0) rd_viol++;
    end
    if (bus.sram_cen === 1'b0) sram_acc++;
    if (bus.sram_cen === 1'b0 && bus.sram_wen === 1'b0) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(bus.sram_addr);
      wr_data.push_back(bus.sram_d);
      mem[bus.sram_addr] = bus.sram_d;
    end
`ifdef OFIFO_DRAIN_ACC_EN
    bus.sram_q = q_pend_v ? q_pend : DW'($urandom);
`endif
    if (bus.sram_cen === 1'b0 && bus.sram_wen === 1'b1) begin
      q_pend   = mem[bus.sram_addr];
      q_pend_v = 1'b1;
    end else begin
      q_pend_v = 1'b0;
    end
    for (int k = RD_LAT; k > 0; k--) pipe[k] = pipe[k-1];
    if (bus.ofifo_rd === 1'b1 && fifo_q.size() > 0) pipe[0] = fifo_q.pop_front();
    else                                            pipe[0] = DW'($urandom);
    bus.ofifo_data = pipe[RD_LAT];
    if (to_produce.size() > 0 && cyc >= produce_from &&
        (!gappy || $urandom_range(0, 2) != 0))
      fifo_q.push_back(to_produce.pop_front());
    bus.ofifo_valid = (fifo_q.size() > 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic clear_logs();
    rd_cyc.delete();
    wr_cyc.delete();
    wr_addr.delete();
    wr_data.delete();
    done_cyc.delete();
    rd_viol  = 0;
    sram_acc = 0;
  endtask

  task automatic run_job(input int n, input int base, input int delay, input bit gaps,
                         input bit pattern, input bit acc, input bit stray, input string name);
    logic [DW-1:0]  v;
    logic [ABW-1:0] a;
    logic [DW-1:0]  exp_d[$];
    logic [ABW-1:0] exp_a[$];
    int             s_cyc;
    clear_logs();
    for (int i = 0; i < n; i++) begin
      v = pattern ? DW'(32'h11111111 * (i + 1)) : DW'($urandom);
      a = ABW'((base + i) & AMASK);
      to_produce.push_back(v);
      exp_a.push_back(a);
      exp_d.push_back(acc ? col_sum(v, mem[a]) : v);
    end
    produce_from  = cyc + delay;
    gappy         = gaps;
    bus.start     = 1'b1;
    bus.num_vec   = ABW'(n);
    bus.base_addr = ABW'(base);
`ifdef OFIFO_DRAIN_ACC_EN
    bus.acc       = acc;
`endif
    s_cyc = cyc;
    cycle();
    // Scramble the request inputs: the job must use the latched copies.
    bus.start     = 1'b0;
    bus.num_vec   = ABW'($urandom);
    bus.base_addr = ABW'($urandom);
`ifdef OFIFO_DRAIN_ACC_EN
    bus.acc       = ~acc;
`endif
    for (int t = 0; t < 3000 && done_cyc.size() == 0; t++) begin
      bus.start = stray && (cyc == s_cyc + 3);
      cycle();
    end
    bus.start = 1'b0;
    repeat (3) cycle();

    check({name, " done_count"}, done_cyc.size(), 1);
    check({name, " busy_after_start"}, busy_at[s_cyc+1], 1);
    if (done_cyc.size() > 0) begin
      if (n == 0) check({name, " done_latency"}, done_cyc[0], s_cyc + 1);
      else if (wr_cyc.size() > 0)
        check({name, " done_after_last_wr"}, done_cyc[0], wr_cyc[wr_cyc.size()-1] + 1);
      check({name, " busy_after_done"}, busy_at[done_cyc[0]+1], 0);
    end
    check({name, " wr_count"}, wr_cyc.size(), n);
    for (int i = 0; i < n && i < wr_cyc.size(); i++) begin
      check($sformatf("%s wr%0d_addr", name, i), wr_addr[i], exp_a[i]);
      check($sformatf("%s wr%0d_data", name, i), wr_data[i], exp_d[i]);
    end
    check({name, " rd_count"}, rd_cyc.size(), n);
    check({name, " rd_while_empty"}, rd_viol, 0);
    if (delay == 0 && !gaps)
      for (int i = 1; i < rd_cyc.size(); i++)
        check($sformatf("%s rd_spacing%0d", name, i), rd_cyc[i] - rd_cyc[i-1],
              RD_LAT + 2 + (acc ? 2 : 0));
    if (n == 0) check({name, " sram_untouched"}, sram_acc, 0);
  endtask

  task automatic reset_mid_job();
    int r_cyc;
    clear_logs();
    for (int i = 0; i < 4; i++) to_produce.push_back(DW'($urandom));
    produce_from  = cyc;
    gappy         = 1'b0;
    bus.start     = 1'b1;
    bus.num_vec   = ABW'(4);
    bus.base_addr = ABW'(12'h100);
`ifdef OFIFO_DRAIN_ACC_EN
    bus.acc       = 1'b0;
`endif
    cycle();
    bus.start = 1'b0;
    for (int t = 0; t < 200 && rd_cyc.size() < 2; t++) cycle();
    check("rst reach_vec2_lat", rd_cyc.size(), 2);
    check("rst wr_before", wr_cyc.size(), 1);
    reset = 1'b1;
    r_cyc = cyc;
    cycle();
    reset = 1'b0;
    fifo_q.delete();
    to_produce.delete();
    repeat (8) cycle();
    check("rst no_wr_after", wr_cyc.size(), 1);
    check("rst busy_next", busy_at[r_cyc+1], 0);
    check("rst no_done", done_cyc.size(), 0);
    check("rst no_more_rd", rd_cyc.size(), 2);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    reset = 1'b1;
    bus.start       = 1'b0;
    bus.num_vec     = '0;
    bus.base_addr   = '0;
    bus.ofifo_valid = 1'b0;
    bus.ofifo_data  = '0;
`ifdef OFIFO_DRAIN_ACC_EN
    bus.acc    = 1'b0;
    bus.sram_q = '0;
`endif
    q_pend   = '0;
    q_pend_v = 1'b0;
    for (int i = 0; i <= RD_LAT; i++) pipe[i] = '0;
    for (int i = 0; i <= AMASK; i++) mem[i] = DW'($urandom);
    clear_logs();
    @(negedge clk);

    repeat (3) cycle();
    check("reset ofifo_rd",  bus.ofifo_rd, 0);
    check("reset sram_cen",  bus.sram_cen, 1);
    check("reset sram_wen",  bus.sram_wen, 1);
    check("reset sram_addr", bus.sram_addr, 0);
    check("reset sram_d",    bus.sram_d, 0);
    check("reset busy",      bus.busy, 0);
    check("reset done",      bus.done, 0);
    check("reset rd_seen",   rd_cyc.size(), 0);
    reset = 1'b0;
    cycle();

    run_job(4, 'h10,  0,  1'b0, 1'b1, 1'b0, 1'b0, "seq4");
    run_job(0, 'h55,  0,  1'b0, 1'b0, 1'b0, 1'b0, "zero");
    run_job(3, 'h20,  10, 1'b0, 1'b1, 1'b0, 1'b0, "empty10");
    run_job(3, 'h7FE, 0,  1'b0, 1'b0, 1'b0, 1'b0, "wrap");
    reset_mid_job();
    run_job(4, 'h30,  0,  1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

`ifdef OFIFO_DRAIN_ACC_EN
    mem['h200] = 32'h77777777;
    run_job(1, 'h200, 0, 1'b0, 1'b1, 1'b1, 1'b0, "acc");
    if (wr_data.size() > 0) check("acc value", wr_data[0], 32'h88888888);
    else                    check("acc value", 64'hDEAD, 32'h88888888);
    run_job(3, 'h300, 0, 1'b0, 1'b0, 1'b1, 1'b0, "acc3");
    run_job(3, 'h400, 0, 1'b0, 1'b0, 1'b0, 1'b0, "acc_off");
`endif

    for (int j = 0; j < 12; j++) begin
      bit ra;
      ra = 1'b0;
`ifdef OFIFO_DRAIN_ACC_EN
      ra = $urandom_range(0, 1) == 1;
`endif
      run_job($urandom_range(1, 6), $urandom_range(0, AMASK), $urandom_range(0, 4),
              $urandom_range(0, 1) == 1, 1'b0, ra, 1'b1, $sformatf("rnd%0d", j));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
